// File: rtl/cnt_enable_gen.sv
// cnt_enable_gen: enable sequencer feeding the count-enable of a 4-bit up-counter.
// A programmable prescaler sets the pulse period. Control inputs give run, stop,
// single-step and fixed-length burst operation.
//
// Ports:
//   clk       rising-edge system clock
//   rst       asynchronous active-low reset
//   start     begin a run (sampled in IDLE)
//   stop      abort a run (sampled in RUN)
//   step      one enable pulse per cycle sampled high while idle
//   div       enable period minus 1
//   burst_len pulses per run; 0 = continuous until stop
//   enable    registered count-enable
//   busy      high while in RUN
//   done      one-cycle pulse after a burst completes
module cnt_enable_gen #(
  parameter int DIV_WIDTH   = 8,
  parameter int BURST_WIDTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   stop,
  input  logic                   step,
  input  logic [DIV_WIDTH-1:0]   div,
  input  logic [BURST_WIDTH-1:0] burst_len,
  output logic                   enable,
  output logic                   busy,
  output logic                   done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [DIV_WIDTH-1:0]   presc_q, presc_d;
  logic [BURST_WIDTH-1:0] cnt_q, cnt_d;
  logic [DIV_WIDTH-1:0]   div_l_q, div_l_d;
  logic [BURST_WIDTH-1:0] len_l_q, len_l_d;
  logic                   enable_q, enable_d;
  logic                   done_q, done_d;

  always_comb begin
    state_d  = state_q;
    presc_d  = presc_q;
    cnt_d    = cnt_q;
    div_l_d  = div_l_q;
    len_l_d  = len_l_q;
    enable_d = 1'b0;
    done_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          div_l_d = div;
          len_l_d = burst_len;
          presc_d = '0;
          cnt_d   = '0;
          state_d = RUN;
        end else if (step) begin
          enable_d = 1'b1;
        end
      end
      RUN: begin
        if (stop) begin
          presc_d = '0;
          cnt_d   = '0;
          state_d = IDLE;
        end else if (presc_q == div_l_q) begin
          // Compare happens before increment, so div = all-ones never overflows.
          enable_d = 1'b1;
          presc_d  = '0;
          cnt_d    = cnt_q + 1'b1;
          if ((len_l_q != '0) && (cnt_d == len_l_q)) begin
            state_d = DONE;
          end
        end else begin
          presc_d = presc_q + 1'b1;
        end
      end
      DONE: begin
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      presc_q  <= '0;
      cnt_q    <= '0;
      div_l_q  <= '0;
      len_l_q  <= '0;
      enable_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      presc_q  <= presc_d;
      cnt_q    <= cnt_d;
      div_l_q  <= div_l_d;
      len_l_q  <= len_l_d;
      enable_q <= enable_d;
      done_q   <= done_d;
    end
  end

  assign enable = enable_q;
  assign busy   = (state_q == RUN);
  assign done   = done_q;

endmodule

// File: tb/tb_cnt_enable_gen.sv
module tb_cnt_enable_gen;

  logic       clk;
  logic       rst;
  logic       start;
  logic       stop;
  logic       step;
  logic [7:0] div;
  logic [3:0] burst_len;
  logic       enable;
  logic       busy;
  logic       done;

  int n_cmp = 0;
  int n_err = 0;
  int ctr   = 0;  // model of the downstream counter (enable-high cycles seen)

  cnt_enable_gen #(.DIV_WIDTH(8), .BURST_WIDTH(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .stop      (stop),
    .step      (step),
    .div       (div),
    .burst_len (burst_len),
    .enable    (enable),
    .busy      (busy),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  // Advance one edge, then sample 1ns later.
  task automatic tick();
    @(posedge clk);
    #1;
    if (enable === 1'b1) ctr++;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  initial begin
    int highs;
    rst = 1'b0; start = 1'b1; stop = 1'b0; step = 1'b0;
    div = 8'd0; burst_len = 4'd15;

    // 1. Reset held with start high
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("rst_enable", {31'd0, enable}, 0);
      chk("rst_busy",   {31'd0, busy},   0);
      chk("rst_done",   {31'd0, done},   0);
    end
    rst = 1'b1;
    ctr = 0;

    // 2. div=0, burst 15: start sampled on first edge out of reset (T0)
    tick();
    start = 1'b0;
    chk("t2_t0_enable", {31'd0, enable}, 0);
    chk("t2_t0_busy",   {31'd0, busy},   1);
    for (int t = 1; t <= 15; t++) begin
      tick();
      chk("t2_enable", {31'd0, enable}, 1);
      chk("t2_done",   {31'd0, done},   0);
    end
    tick();  // T0+16
    chk("t2_done_pulse", {31'd0, done},   1);
    chk("t2_enable_off", {31'd0, enable}, 0);
    chk("t2_busy_off",   {31'd0, busy},   0);
    tick();  // T0+17
    chk("t2_done_clear", {31'd0, done}, 0);
    chk("t2_count",      ctr, 15);

    // 3. div=3, burst 4; div changed mid-run
    div = 8'd3; burst_len = 4'd4; start = 1'b1; ctr = 0;
    tick();
    start = 1'b0; div = 8'd0;
    for (int t = 1; t <= 16; t++) begin
      tick();
      chk("t3_enable", {31'd0, enable}, (t % 4 == 0) ? 1 : 0);
      chk("t3_done",   {31'd0, done},   0);
    end
    tick();  // T0+17
    chk("t3_done_pulse", {31'd0, done},   1);
    chk("t3_enable_off", {31'd0, enable}, 0);
    tick();
    chk("t3_done_clear", {31'd0, done}, 0);
    chk("t3_count",      ctr, 4);

    // 4. div=2 continuous, stop on the edge a pulse is due
    div = 8'd2; burst_len = 4'd0; start = 1'b1;
    tick();
    start = 1'b0;
    for (int t = 1; t <= 8; t++) begin
      tick();
      chk("t4_enable", {31'd0, enable}, (t % 3 == 0) ? 1 : 0);
      chk("t4_busy",   {31'd0, busy},   1);
    end
    stop = 1'b1;
    tick();  // T0+9: pulse would be due
    stop = 1'b0;
    chk("t4_stop_enable", {31'd0, enable}, 0);
    chk("t4_stop_busy",   {31'd0, busy},   0);
    chk("t4_stop_done",   {31'd0, done},   0);
    tick();
    chk("t4_idle_done",   {31'd0, done},   0);
    chk("t4_idle_enable", {31'd0, enable}, 0);

    // 5. Single step, held step, start+step, step during RUN
    ctr = 0; step = 1'b1;
    tick();
    step = 1'b0;
    chk("t5_step_enable", {31'd0, enable}, 1);
    chk("t5_step_busy",   {31'd0, busy},   0);
    tick();
    chk("t5_step_off", {31'd0, enable}, 0);
    chk("t5_step_cnt", ctr, 1);
    step = 1'b1;
    tick();
    chk("t5_held1", {31'd0, enable}, 1);
    tick();
    step = 1'b0;
    chk("t5_held2", {31'd0, enable}, 1);
    tick();
    chk("t5_held_off", {31'd0, enable}, 0);
    div = 8'd1; burst_len = 4'd2; start = 1'b1; step = 1'b1;
    tick();  // T0
    start = 1'b0;
    chk("t5_ss_enable", {31'd0, enable}, 0);
    chk("t5_ss_busy",   {31'd0, busy},   1);
    for (int t = 1; t <= 4; t++) begin
      tick();
      chk("t5_run_enable", {31'd0, enable}, (t % 2 == 0) ? 1 : 0);
    end
    tick();  // T0+5: DONE edge, step still high
    step = 1'b0;
    chk("t5_done_pulse", {31'd0, done},   1);
    chk("t5_done_enable", {31'd0, enable}, 0);
    tick();
    chk("t5_done_clear", {31'd0, done}, 0);

    // 6. Reset mid-burst, then a full restart
    div = 8'd1; burst_len = 4'd8; start = 1'b1;
    tick();
    start = 1'b0;
    for (int t = 1; t <= 6; t++) tick();
    chk("t6_pre_rst_enable", {31'd0, enable}, 1);
    rst = 1'b0;
    #1;
    chk("t6_async_enable", {31'd0, enable}, 0);
    chk("t6_async_busy",   {31'd0, busy},   0);
    chk("t6_async_done",   {31'd0, done},   0);
    tick();
    tick();
    chk("t6_rst_done", {31'd0, done}, 0);
    rst = 1'b1; start = 1'b1; ctr = 0;
    tick();
    start = 1'b0;
    for (int t = 1; t <= 16; t++) begin
      tick();
      chk("t6_enable", {31'd0, enable}, (t % 2 == 0) ? 1 : 0);
    end
    tick();
    chk("t6_done_pulse", {31'd0, done}, 1);
    chk("t6_count",      ctr, 8);

    // 7. div all-ones: period 256, burst 1
    div = 8'hFF; burst_len = 4'd1; start = 1'b1;
    tick();
    start = 1'b0;
    highs = 0;
    for (int t = 1; t <= 255; t++) begin
      tick();
      if (enable === 1'b1) highs++;
    end
    chk("t7_quiet", highs, 0);
    tick();  // T0+256
    chk("t7_enable", {31'd0, enable}, 1);
    tick();
    chk("t7_done", {31'd0, done},   1);
    chk("t7_off",  {31'd0, enable}, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
